// File: rtl/ltile_clb__frac_logic_k_pkg.sv
// frac_logic_pkg: shared frame-layout helpers for the fractured LUT logic element
package frac_logic_pkg;

    // Frame width: 2^k truth-table bits followed by three mode bits
    function automatic int cfg_w(input int k);
        return (1 << k) + 3;
    endfunction

    // Mode-bit positions, counted from the end of the truth table
    localparam int OFF_OUT0_SEL = 0;
    localparam int OFF_REG0_EN  = 1;
    localparam int OFF_REG1_EN  = 2;

endpackage

// File: rtl/ltile_clb__frac_logic_k_if.sv
// ltile_clb__frac_logic_k_if: logic inputs, config chain and outputs of one logic element
interface ltile_clb__frac_logic_k_if #(parameter int K = 4);

    logic [K-1:0] frac_logic_in;
    logic         ccff_head;
    logic         ccff_en;
    logic         ccff_commit;
    logic         fle_en;
    logic [1:0]   frac_logic_out;
    logic         ccff_tail;
    logic         cfg_loaded;

    modport master (
        output frac_logic_in, ccff_head, ccff_en, ccff_commit, fle_en,
        input  frac_logic_out, ccff_tail, cfg_loaded
    );

    modport slave (
        input  frac_logic_in, ccff_head, ccff_en, ccff_commit, fle_en,
        output frac_logic_out, ccff_tail, cfg_loaded
    );

endinterface

// File: rtl/ltile_clb__frac_logic_k_chain.sv
// ccff_shadow_chain: serial config shift chain with a shadow copy and a frame bit counter
module ccff_shadow_chain #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         head,
    input  logic         en,
    input  logic         commit,
    output logic [W-1:0] cfg,
    output logic         tail,
    output logic         loaded
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    // Shift on enable; commit snapshots the pre-shift chain and restarts the bit count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cfg <= '0;
            cnt <= '0;
        end else begin
            if (en) sr <= {sr[W-2:0], head};
            if (commit) cfg <= sr;
            if (commit) cnt <= en ? CW'(1) : '0;
            else if (en && cnt != CW'(W)) cnt <= cnt + 1'b1;
        end
    end

    assign tail   = sr[W-1];
    assign loaded = (cnt == CW'(W));

endmodule

// File: rtl/ltile_clb__frac_logic_k.sv
// ltile_clb__frac_logic_k: K-input fractured LUT with shadowed config and bypassable output registers
module ltile_clb__frac_logic_k
    import frac_logic_pkg::*;
#(
    parameter int K = 4
) (
    input logic                     prog_clk,
    input logic                     prog_reset,
    ltile_clb__frac_logic_k_if.slave bus
);

    localparam int N     = 1 << K;
    localparam int CFG_W = cfg_w(K);

    logic [CFG_W-1:0] cfg;
    logic [N-1:0]     tt;
    logic [K-2:0]     a_lo;
    logic             lut_k, lut_lo, lut_hi;
    logic             out0_sel, reg0_en, reg1_en;
    logic [1:0]       comb, q;

    ccff_shadow_chain #(.W(CFG_W)) u_chain (
        .clk    (prog_clk),
        .rst    (prog_reset),
        .head   (bus.ccff_head),
        .en     (bus.ccff_en),
        .commit (bus.ccff_commit),
        .cfg    (cfg),
        .tail   (bus.ccff_tail),
        .loaded (bus.cfg_loaded)
    );

    assign tt       = cfg[N-1:0];
    assign out0_sel = cfg[N + OFF_OUT0_SEL];
    assign reg0_en  = cfg[N + OFF_REG0_EN];
    assign reg1_en  = cfg[N + OFF_REG1_EN];

    // The two halves of the table act as independent (K-1)-input LUTs in fractured mode
    assign a_lo   = bus.frac_logic_in[K-2:0];
    assign lut_k  = tt[bus.frac_logic_in];
    assign lut_lo = tt[{1'b0, a_lo}];
    assign lut_hi = tt[{1'b1, a_lo}];
    assign comb   = {lut_hi, out0_sel ? lut_lo : lut_k};

    // Output registers sample the combinational results when enabled
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) q <= '0;
        else if (bus.fle_en) q <= comb;
    end

    assign bus.frac_logic_out = {reg1_en ? q[1] : comb[1], reg0_en ? q[0] : comb[0]};

endmodule

// File: tb/tb_ltile_clb__frac_logic_k.sv
// tb_ltile_clb__frac_logic_k: directed checks of the K=4 fractured logic element
module tb_ltile_clb__frac_logic_k;

    localparam int K = 4;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b1;
    int   checks     = 0;
    int   fails      = 0;

    ltile_clb__frac_logic_k_if #(.K(K)) bus ();

    ltile_clb__frac_logic_k #(.K(K)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .bus        (bus)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bus.ccff_head = b;
        bus.ccff_en   = 1'b1;
        tick();
        bus.ccff_en   = 1'b0;
    endtask

    task automatic load(input logic [18:0] f);
        for (int i = 18; i >= 0; i--) shift_bit(f[i]);
    endtask

    task automatic commit();
        bus.ccff_commit = 1'b1;
        tick();
        bus.ccff_commit = 1'b0;
    endtask

    task automatic set_in(input logic [3:0] v);
        bus.frac_logic_in = v;
        #1;
    endtask

    initial begin
        logic [18:0] f;
        logic [39:0] pat;
        logic [3:0]  v;
        logic        last;
        int          n;
        bus.frac_logic_in = '0;
        bus.ccff_head     = 1'b0;
        bus.ccff_en       = 1'b0;
        bus.ccff_commit   = 1'b0;
        bus.fle_en        = 1'b0;
        #3;
        check("rst_out", bus.frac_logic_out, 2'b00);
        check("rst_tail", bus.ccff_tail, 1'b0);
        check("rst_loaded", bus.cfg_loaded, 1'b0);
        @(negedge prog_clk);
        prog_reset = 1'b0;

        // Reset mid-shift must clear everything without a clock edge
        load({3'b000, 16'hFFFF});
        commit();
        check("ones_out", bus.frac_logic_out, 2'b11);
        for (int i = 0; i < 19; i++) shift_bit(1'b1);
        check("ones_tail", bus.ccff_tail, 1'b1);
        check("ones_loaded", bus.cfg_loaded, 1'b1);
        bus.ccff_head = 1'b1;
        bus.ccff_en   = 1'b1;
        #2 prog_reset = 1'b1;
        #1;
        check("arst_out", bus.frac_logic_out, 2'b00);
        check("arst_tail", bus.ccff_tail, 1'b0);
        check("arst_loaded", bus.cfg_loaded, 1'b0);
        #2;
        bus.ccff_en = 1'b0;
        prog_reset  = 1'b0;
        for (int i = 0; i < 18; i++) shift_bit(1'b0);
        check("arst_18_loaded", bus.cfg_loaded, 1'b0);
        shift_bit(1'b0);
        check("arst_19_loaded", bus.cfg_loaded, 1'b1);

        // Full LUT4 AND load, with cfg_loaded tracking
        commit();
        check("lut4_cnt_clr", bus.cfg_loaded, 1'b0);
        f = {3'b000, 16'h8000};
        for (int i = 18; i >= 1; i--) shift_bit(f[i]);
        check("lut4_18_loaded", bus.cfg_loaded, 1'b0);
        shift_bit(f[0]);
        check("lut4_19_loaded", bus.cfg_loaded, 1'b1);
        commit();
        check("lut4_commit_loaded", bus.cfg_loaded, 1'b0);
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_in(v);
            check("lut4_out0", bus.frac_logic_out[0], v == 4'hF);
            check("lut4_out1", bus.frac_logic_out[1], v[2:0] == 3'b111);
        end

        // Fractured mode: parity table read as two 3-input halves
        load({3'b001, 16'h6996});
        commit();
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            set_in(v);
            check("frac_xor", bus.frac_logic_out[0], ^v[2:0]);
            check("frac_xnor", bus.frac_logic_out[1], ~^v[2:0]);
        end

        // Shadow isolation: AND stays live while a NAND frame is shifted
        load({3'b000, 16'h8000});
        commit();
        f = {3'b000, 16'h7FFF};
        for (int i = 18; i >= 0; i--) begin
            v = 4'((i * 5) % 16);
            set_in(v);
            check("shadow_and", bus.frac_logic_out[0], &v);
            shift_bit(f[i]);
        end
        set_in(4'hF);
        bus.ccff_commit = 1'b1;
        #1;
        check("shadow_pre_edge", bus.frac_logic_out[0], 1'b1);
        tick();
        bus.ccff_commit = 1'b0;
        check("shadow_nand_f", bus.frac_logic_out[0], 1'b0);
        set_in(4'h0);
        check("shadow_nand_0", bus.frac_logic_out[0], 1'b1);

        // Registered output 0, bypassed output 1
        load({3'b010, 16'h8000});
        commit();
        set_in(4'hF);
        check("reg_q_init", bus.frac_logic_out[0], 1'b0);
        check("reg_bypass1", bus.frac_logic_out[1], 1'b1);
        bus.fle_en = 1'b1;
        tick();
        bus.fle_en = 1'b0;
        check("reg_sampled", bus.frac_logic_out[0], 1'b1);
        set_in(4'h0);
        check("reg_hold_in", bus.frac_logic_out[0], 1'b1);
        check("reg_bypass1_0", bus.frac_logic_out[1], 1'b0);
        tick();
        tick();
        check("reg_hold_clk", bus.frac_logic_out[0], 1'b1);

        // Pass-through with held cycles, after a fresh reset
        #2 prog_reset = 1'b1;
        #2 prog_reset = 1'b0;
        pat  = {21'h15A5A5, 3'b000, 16'h8000};
        n    = 0;
        last = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            if (i % 7 == 3) begin
                tick();
                check("pass_hold", bus.ccff_tail, last);
            end
            shift_bit(pat[i]);
            n++;
            last = (n >= 19) ? pat[58 - n] : 1'b0;
            check("pass_tail", bus.ccff_tail, last);
        end
        check("pass_sat_loaded", bus.cfg_loaded, 1'b1);

        // Simultaneous shift and commit: pre-shift frame captured, count restarts at 1
        bus.ccff_head   = 1'b1;
        bus.ccff_en     = 1'b1;
        bus.ccff_commit = 1'b1;
        tick();
        bus.ccff_en     = 1'b0;
        bus.ccff_commit = 1'b0;
        check("sim_loaded", bus.cfg_loaded, 1'b0);
        set_in(4'h0);
        check("sim_cfg_in0", bus.frac_logic_out[0], 1'b0);
        set_in(4'hF);
        check("sim_cfg_inF", bus.frac_logic_out[0], 1'b1);
        for (int i = 0; i < 17; i++) shift_bit(1'b0);
        check("sim_cnt18", bus.cfg_loaded, 1'b0);
        shift_bit(1'b0);
        check("sim_cnt19", bus.cfg_loaded, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ltile_clb__frac_logic_k.md
# ltile_clb__frac_logic_k

Parametrised fractured-LUT logic element for the CLB logical tile, generalising the fixed 4-input fractured logic element to K inputs. It adds a shadowed configuration chain: shifting happens on `prog_clk` without disturbing live logic, and an explicit commit applies the new configuration. It also adds per-output registers with configurable bypass and a bit counter that reports when a full frame has been shifted. It sits in the CLB between the input crossbar and the output routing, daisy-chained on `ccff_head`/`ccff_tail`.

## Interface
Parameters:
- `K`, default 4: LUT input count; legal range 3..6.
- `CFG_W`, derived as 2^K + 3: configuration frame width in bits; not overridable.

Ports:
- `prog_clk`  in  1  sole clock for the chain, shadow, counter and output registers.
- `prog_reset`  in  1  asynchronous, active-high reset.
- `frac_logic_in`  in  K  LUT inputs; index 0 is the LSB of the LUT address.
- `ccff_head`  in  1  serial configuration input.
- `ccff_en`  in  1  shift enable.
- `ccff_commit`  in  1  copies the shift chain into the shadow configuration.
- `fle_en`  in  1  clock enable for the output registers.
- `frac_logic_out`  out  2  logic outputs.
- `ccff_tail`  out  1  serial configuration output.
- `cfg_loaded`  out  1  high once CFG_W bits have been shifted since the last commit or reset.

## Operation
- The shift register `sr[CFG_W-1:0]` updates only when `ccff_en`=1: `sr <= {sr[CFG_W-2:0], ccff_head}`. `ccff_tail` = `sr[CFG_W-1]`.
- The first bit shifted in lands in `sr[CFG_W-1]` after CFG_W shifts.
- The shadow register `cfg[CFG_W-1:0]` loads `sr` on `ccff_commit`=1. All logic uses `cfg`, never `sr`.
- Frame map:
  - `cfg[2^K-1:0]`: LUT truth table.
  - `cfg[2^K]`: `out0_sel`.
  - `cfg[2^K+1]`: `reg0_en`.
  - `cfg[2^K+2]`: `reg1_en`.
- LUT combinational outputs, with `a` = `frac_logic_in`:
  - `lut_k` = `cfg[a]`.
  - `lut_lo` = `cfg[{1'b0, a[K-2:0]}]`.
  - `lut_hi` = `cfg[{1'b1, a[K-2:0]}]`.
- Output functions:
  - `comb0` = `out0_sel` ? `lut_lo` : `lut_k`.
  - `comb1` = `lut_hi`.
- Output registers `q[1:0]` load `{comb1, comb0}` when `fle_en`=1.
- `frac_logic_out[i]` = `reg{i}_en` ? `q[i]` : `comb[i]`.
- Bit counter `cnt`, width $clog2(CFG_W+1):
  - Increments on each `ccff_en` cycle and saturates at CFG_W.
  - `cfg_loaded` = (`cnt` == CFG_W).
  - `ccff_commit` clears `cnt` to 0.
  - If `ccff_commit` and `ccff_en` are both high in the same cycle, `cnt` becomes 1.
- Simultaneous `ccff_en` and `ccff_commit`: `cfg` captures the pre-shift `sr`, and the shift proceeds in the same edge.
- A commit before `cfg_loaded` is legal; it applies whatever is in `sr`.

## Timing
- Reset values: `sr`, `cfg`, `q` and `cnt` are all 0. Therefore `frac_logic_out` = 2'b00, `ccff_tail` = 0 and `cfg_loaded` = 0.
- Asserting `prog_reset` mid-shift or mid-commit discards all state immediately, with no wait for a clock edge.
- `ccff_head` to `ccff_tail` latency is CFG_W enabled cycles. Disabled cycles hold the chain.
- Commit latency: the new `cfg` is visible on combinational outputs one cycle after the `ccff_commit` edge.
- Registered path: `frac_logic_out` reflects `comb` sampled at the `fle_en` edge, with 1 cycle of latency.
- The bypassed path is purely combinational from `frac_logic_in` and `cfg`.
- Switching `reg_en` via commit takes effect immediately on the mux. `q` retains its last sampled value.

## Structure
- Shared package `frac_logic_pkg`:
  - `function cfg_w(k)` returning 2^k + 3.
  - Localparam offsets `OFF_OUT0_SEL`, `OFF_REG0_EN`, `OFF_REG1_EN` relative to 2^K.
- One sub-module: `ccff_shadow_chain #(W)`, containing `sr`, `cfg`, `cnt`, `ccff_tail` and `cfg_loaded`. It is reusable by other tiles.
- LUT read, muxes and output registers stay in the top module.

## Test plan
- **Reset:** with K=4 (CFG_W=19), assert `prog_reset` mid-shift. Required: `frac_logic_out`=00, `ccff_tail`=0 and `cfg_loaded`=0 asynchronously, and `cfg_loaded` stays 0 until 19 fresh shifts.
- **Full LUT4 load:** shift table 16'h8000 with `out0_sel`=0 and `reg*_en`=0, then commit. Required: `frac_logic_out[0]`=1 only for `in`=4'hF, and `cfg_loaded` rises on the 19th shift and clears on commit.
- **Fractured mode:** load table 16'h6996 with `out0_sel`=1. Required: `out[0]` = 3-input XOR of `in[2:0]` from the low half, and `out[1]` = XNOR from the high half, for all 16 inputs.
- **Shadow isolation:** with an AND function committed, shift a new frame while toggling inputs. Required: outputs match AND until commit, then switch one cycle after the commit edge.
- **Registered outputs:** set `reg0_en`=1 and pulse `fle_en` once with `in`=4'hF under 16'h8000. Required: `out[0]`=1 one cycle later and holds after `in` changes, with `fle_en`=0.
- **Pass-through and simultaneity:** shift a 40-bit pattern. Required: `ccff_tail` reproduces it delayed 19 enabled cycles. With `ccff_en` and `ccff_commit` high together, `cfg` gets the pre-shift frame and `cnt`=1.
